// File: rtl/nv_nvdla_pdp_rdma_split_sched.sv
// Split-width scheduler for the PDP read-DMA path.
// Each layer start walks split_num+1 horizontal splits. One command is issued to
// ingress at a time. The scheduler then waits for egress to report that split
// drained, and advances the x offset by the split width less the kernel overlap.
// When the last split drains it pulses layer completion to the register file.
// Optional feature macro: NVDLA_PDP_SPLIT_PERF_EN adds the dp2reg_split_stall counter.
module nv_nvdla_pdp_rdma_split_sched #(
  parameter int SPLIT_W = 8,
  parameter int X_W     = 13,
  parameter int PW_W    = 10
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        reg2dp_op_en,
  input  logic [SPLIT_W-1:0]          reg2dp_split_num,
  input  logic [X_W-1:0]              reg2dp_cube_in_width,
  input  logic [PW_W-1:0]             reg2dp_partial_width_in_first,
  input  logic [PW_W-1:0]             reg2dp_partial_width_in_mid,
  input  logic [PW_W-1:0]             reg2dp_partial_width_in_last,
  input  logic [3:0]                  reg2dp_kernel_width,
  input  logic [3:0]                  reg2dp_kernel_stride_width,
  output logic                        split2ig_pvld,
  input  logic                        split2ig_prdy,
  output logic [SPLIT_W+PW_W+X_W+1:0] split2ig_pd,
  input  logic                        eg2split_done,
  output logic                        split2reg_done,
  output logic                        split_busy
`ifdef NVDLA_PDP_SPLIT_PERF_EN
  ,
  output logic [31:0]                 dp2reg_split_stall
`endif
);

  localparam int PD_W = SPLIT_W + PW_W + X_W + 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              state_reg, state_next;
  logic                op_en_d_reg;
  logic [SPLIT_W-1:0]  split_num_reg, split_num_next;
  logic [PW_W-1:0]     cube_w_reg, cube_w_next;
  logic [PW_W-1:0]     first_reg, first_next;
  logic [PW_W-1:0]     mid_reg, mid_next;
  logic [PW_W-1:0]     last_reg, last_next;
  logic [3:0]          kw_reg, kw_next;
  logic [3:0]          ks_reg, ks_next;
  logic [SPLIT_W-1:0]  idx_reg, idx_next;
  logic [X_W-1:0]      x_start_reg, x_start_next;
  logic                pvld_reg, pvld_next;
  logic [PD_W-1:0]     pd_reg, pd_next;
  logic                done_reg, done_next;
  logic                busy_reg, busy_next;
  logic                load_pd;

  logic                start;
  logic                abort;
  logic [PW_W-1:0]     cur_width;
  logic [3:0]          overlap;
  logic [X_W-1:0]      step;

  // Width of split idx. An unsplit layer uses the cube width, which is assumed to fit the partial-width field.
  function automatic logic [PW_W-1:0] sel_width(
    input logic [SPLIT_W-1:0] num,
    input logic [SPLIT_W-1:0] idx,
    input logic [PW_W-1:0]    cube,
    input logic [PW_W-1:0]    fw,
    input logic [PW_W-1:0]    mw,
    input logic [PW_W-1:0]    lw
  );
    if (num == '0)       return cube;
    else if (idx == '0)  return fw;
    else if (idx == num) return lw;
    else                 return mw;
  endfunction

  assign start     = reg2dp_op_en & ~op_en_d_reg;
  assign abort     = op_en_d_reg & ~reg2dp_op_en;
  assign cur_width = sel_width(split_num_reg, idx_reg, cube_w_reg, first_reg, mid_reg, last_reg);
  // Adjacent splits share (kernel - stride) columns. The shared amount is zero when the stride covers the kernel.
  assign overlap   = (kw_reg > ks_reg) ? (kw_reg - ks_reg) : 4'd0;
  assign step      = X_W'(cur_width) + X_W'(1) - X_W'(overlap);

  // Next-state and registered-output computation for the split walk
  always_comb begin
    state_next     = state_reg;
    split_num_next = split_num_reg;
    cube_w_next    = cube_w_reg;
    first_next     = first_reg;
    mid_next       = mid_reg;
    last_next      = last_reg;
    kw_next        = kw_reg;
    ks_next        = ks_reg;
    idx_next       = idx_reg;
    x_start_next   = x_start_reg;
    pvld_next      = pvld_reg;
    pd_next        = pd_reg;
    done_next      = 1'b0;
    busy_next      = busy_reg;
    load_pd        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          split_num_next = reg2dp_split_num;
          cube_w_next    = reg2dp_cube_in_width[PW_W-1:0];
          first_next     = reg2dp_partial_width_in_first;
          mid_next       = reg2dp_partial_width_in_mid;
          last_next      = reg2dp_partial_width_in_last;
          kw_next        = reg2dp_kernel_width;
          ks_next        = reg2dp_kernel_stride_width;
          idx_next       = '0;
          x_start_next   = '0;
          pvld_next      = 1'b1;
          busy_next      = 1'b1;
          load_pd        = 1'b1;
          state_next     = ISSUE;
        end
      end
      ISSUE: begin
        if (pvld_reg && split2ig_prdy) begin
          pvld_next  = 1'b0;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (eg2split_done) begin
          if (idx_reg == split_num_reg) begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = DONE;
          end else begin
            idx_next     = idx_reg + SPLIT_W'(1);
            x_start_next = x_start_reg + step;
            pvld_next    = 1'b1;
            load_pd      = 1'b1;
            state_next   = ISSUE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Dropping op_en withdraws any pending command and abandons the layer silently
    if (abort && state_reg != IDLE) begin
      state_next = IDLE;
      pvld_next  = 1'b0;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      load_pd    = 1'b0;
    end

    // The command word is built only when entering ISSUE, so it stays stable until the handshake
    if (load_pd) begin
      pd_next = {(idx_next == split_num_next), (idx_next == '0), idx_next,
                 sel_width(split_num_next, idx_next, cube_w_next, first_next, mid_next, last_next),
                 x_start_next};
    end
  end

  // State, latched configuration and registered outputs
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_reg     <= IDLE;
      op_en_d_reg   <= 1'b0;
      split_num_reg <= '0;
      cube_w_reg    <= '0;
      first_reg     <= '0;
      mid_reg       <= '0;
      last_reg      <= '0;
      kw_reg        <= '0;
      ks_reg        <= '0;
      idx_reg       <= '0;
      x_start_reg   <= '0;
      pvld_reg      <= 1'b0;
      pd_reg        <= '0;
      done_reg      <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_en_d_reg   <= reg2dp_op_en;
      split_num_reg <= split_num_next;
      cube_w_reg    <= cube_w_next;
      first_reg     <= first_next;
      mid_reg       <= mid_next;
      last_reg      <= last_next;
      kw_reg        <= kw_next;
      ks_reg        <= ks_next;
      idx_reg       <= idx_next;
      x_start_reg   <= x_start_next;
      pvld_reg      <= pvld_next;
      pd_reg        <= pd_next;
      done_reg      <= done_next;
      busy_reg      <= busy_next;
    end
  end

  assign split2ig_pvld  = pvld_reg;
  assign split2ig_pd    = pd_reg;
  assign split2reg_done = done_reg;
  assign split_busy     = busy_reg;

`ifdef NVDLA_PDP_SPLIT_PERF_EN
  logic [31:0] stall_reg;

  // Count cycles where a command waits on ingress. The count saturates and restarts at each accepted layer start.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      stall_reg <= '0;
    end else if (start && state_reg == IDLE) begin
      stall_reg <= '0;
    end else if (pvld_reg && !split2ig_prdy && stall_reg != 32'hFFFF_FFFF) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign dp2reg_split_stall = stall_reg;
`endif

endmodule
